// File: rtl/box_motion_scheduler.sv
// rtl/box_motion_scheduler.sv - per-frame bouncing-box position stepper with registered in-box flag
// Steps the box once per frame at a blanking-time trigger and reflects it off the active-area edges.
module box_motion_scheduler #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_W    = 240,
  parameter int BOX_H    = 160,
  parameter int INIT_H   = 240,
  parameter int INIT_V   = 160,
  parameter int TRIG_H   = 0,
  parameter int TRIG_V   = 480
) (
  input  logic       pixelClock,
  input  logic       resetN,
  input  logic       enable,
  input  logic [9:0] hPosCounter,
  input  logic [9:0] vPosCounter,
  input  logic       inActiveDisplay,
  input  logic [3:0] stepSize,
  output logic [9:0] boxHpos,
  output logic [9:0] boxVpos,
  output logic       dirRight,
  output logic       dirDown,
  output logic       insideBox,
  output logic       frameTick,
  output logic [7:0] bounceCount
);

  typedef enum logic [1:0] {WAIT, STEP_H, STEP_V, DONE} state_t;

  localparam logic [10:0] H_ACT11 = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT11 = 11'(V_ACTIVE);
  localparam logic [10:0] BOX_W11 = 11'(BOX_W);
  localparam logic [10:0] BOX_H11 = 11'(BOX_H);
  localparam logic [9:0]  H_LIMIT = 10'(H_ACTIVE - BOX_W);
  localparam logic [9:0]  V_LIMIT = 10'(V_ACTIVE - BOX_H);
  localparam logic [9:0]  TRIG_H10 = 10'(TRIG_H);
  localparam logic [9:0]  TRIG_V10 = 10'(TRIG_V);

  state_t     state, stateNext;
  logic [3:0] stepReg;
  logic       latchStep, doStepH, doStepV, tickNext;
  logic       trigger;

  logic [10:0] hPos11, vPos11, step11;
  logic        hBounce, vBounce;
  logic [9:0]  hNext, vNext;
  logic        insideNext;

  assign trigger = enable && (hPosCounter == TRIG_H10) && (vPosCounter == TRIG_V10);

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) state <= WAIT;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    latchStep = 1'b0;
    doStepH   = 1'b0;
    doStepV   = 1'b0;
    tickNext  = 1'b0;
    unique case (state)
      WAIT: begin
        if (trigger) begin
          latchStep = 1'b1;
          stateNext = STEP_H;
        end
      end
      STEP_H: begin
        doStepH   = 1'b1;
        stateNext = STEP_V;
      end
      STEP_V: begin
        doStepV   = 1'b1;
        stateNext = DONE;
      end
      DONE: begin
        tickNext  = 1'b1;
        stateNext = WAIT;
      end
    endcase
  end

  // All edge arithmetic is 11 bits wide so box position plus size never wraps.
  assign hPos11 = {1'b0, boxHpos};
  assign vPos11 = {1'b0, boxVpos};
  assign step11 = {7'd0, stepReg};

  always_comb begin
    hBounce = 1'b0;
    hNext   = boxHpos;
    if (dirRight) begin
      hBounce = (hPos11 + step11 + BOX_W11) > H_ACT11;
      hNext   = hBounce ? H_LIMIT : 10'(hPos11 + step11);
    end else begin
      hBounce = hPos11 < step11;
      hNext   = hBounce ? 10'd0 : 10'(hPos11 - step11);
    end
  end

  always_comb begin
    vBounce = 1'b0;
    vNext   = boxVpos;
    if (dirDown) begin
      vBounce = (vPos11 + step11 + BOX_H11) > V_ACT11;
      vNext   = vBounce ? V_LIMIT : 10'(vPos11 + step11);
    end else begin
      vBounce = vPos11 < step11;
      vNext   = vBounce ? 10'd0 : 10'(vPos11 - step11);
    end
  end

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      stepReg     <= 4'd0;
      boxHpos     <= 10'(INIT_H);
      boxVpos     <= 10'(INIT_V);
      dirRight    <= 1'b1;
      dirDown     <= 1'b1;
      bounceCount <= 8'd0;
      frameTick   <= 1'b0;
    end else begin
      frameTick <= tickNext;
      if (latchStep) stepReg <= stepSize;
      if (doStepH) begin
        boxHpos <= hNext;
        if (hBounce) dirRight <= ~dirRight;
      end
      if (doStepV) begin
        boxVpos <= vNext;
        if (vBounce) dirDown <= ~dirDown;
      end
      if (((doStepH && hBounce) || (doStepV && vBounce)) && (bounceCount != 8'hFF))
        bounceCount <= bounceCount + 8'd1;
    end
  end

  assign insideNext = inActiveDisplay
                   && ({1'b0, hPosCounter} >= hPos11)
                   && ({1'b0, hPosCounter} <  (hPos11 + BOX_W11))
                   && ({1'b0, vPosCounter} >= vPos11)
                   && ({1'b0, vPosCounter} <  (vPos11 + BOX_H11));

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) insideBox <= 1'b0;
    else         insideBox <= insideNext;
  end

endmodule

// File: tb/tb_box_motion_scheduler.sv
// tb/tb_box_motion_scheduler.sv - directed self-checking bench for box_motion_scheduler
module tb_box_motion_scheduler;

  logic       pixelClock = 1'b0;
  logic       resetN;
  logic       enable;
  logic [9:0] hPosCounter;
  logic [9:0] vPosCounter;
  logic       inActiveDisplay;
  logic [3:0] stepSize;
  logic [9:0] boxHpos;
  logic [9:0] boxVpos;
  logic       dirRight;
  logic       dirDown;
  logic       insideBox;
  logic       frameTick;
  logic [7:0] bounceCount;

  int nTests = 0;
  int nFail  = 0;
  int ticks;

  always #5 pixelClock = ~pixelClock;

  box_motion_scheduler dut (
    .pixelClock(pixelClock),
    .resetN(resetN),
    .enable(enable),
    .hPosCounter(hPosCounter),
    .vPosCounter(vPosCounter),
    .inActiveDisplay(inActiveDisplay),
    .stepSize(stepSize),
    .boxHpos(boxHpos),
    .boxVpos(boxVpos),
    .dirRight(dirRight),
    .dirDown(dirDown),
    .insideBox(insideBox),
    .frameTick(frameTick),
    .bounceCount(bounceCount)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nTests++;
    assert (observed === expected) else begin
      nFail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic chkPos(input string tag, input int h, input int v, input int r, input int d, input int b);
    chk({tag, "_h"}, 32'(boxHpos), 32'(h));
    chk({tag, "_v"}, 32'(boxVpos), 32'(v));
    chk({tag, "_dirRight"}, 32'(dirRight), 32'(r));
    chk({tag, "_dirDown"}, 32'(dirDown), 32'(d));
    chk({tag, "_bounce"}, 32'(bounceCount), 32'(b));
  endtask

  // Presents the trigger for one rising edge; returns just after that edge.
  task automatic trig();
    hPosCounter = 10'd0;
    vPosCounter = 10'd480;
    @(negedge pixelClock);
    hPosCounter = 10'd1;
    vPosCounter = 10'd0;
  endtask

  task automatic frame(output int nTicks);
    trig();
    nTicks = 0;
    repeat (4) begin
      @(negedge pixelClock);
      if (frameTick === 1'b1) nTicks++;
    end
  endtask

  task automatic doReset();
    resetN = 1'b0;
    @(negedge pixelClock);
    resetN = 1'b1;
    @(negedge pixelClock);
  endtask

  task automatic pix(input string tag, input int h, input int v, input logic act, input int expected);
    hPosCounter     = 10'(h);
    vPosCounter     = 10'(v);
    inActiveDisplay = act;
    @(negedge pixelClock);
    chk(tag, 32'(insideBox), 32'(expected));
  endtask

  initial begin
    resetN          = 1'b0;
    enable          = 1'b0;
    hPosCounter     = 10'd1;
    vPosCounter     = 10'd0;
    inActiveDisplay = 1'b0;
    stepSize        = 4'd0;
    repeat (2) @(negedge pixelClock);
    chkPos("reset", 240, 160, 1, 1, 0);
    chk("reset_tick", 32'(frameTick), 0);
    chk("reset_inside", 32'(insideBox), 0);
    resetN = 1'b1;
    @(negedge pixelClock);

    // first step and trigger-to-tick latency
    stepSize = 4'd1;
    enable   = 1'b1;
    trig();
    @(negedge pixelClock);
    chk("lat_h1", 32'(boxHpos), 241);
    chk("lat_v1", 32'(boxVpos), 160);
    chk("lat_tick1", 32'(frameTick), 0);
    @(negedge pixelClock);
    chk("lat_v2", 32'(boxVpos), 161);
    chk("lat_tick2", 32'(frameTick), 0);
    @(negedge pixelClock);
    chk("lat_tick3", 32'(frameTick), 1);
    @(negedge pixelClock);
    chk("lat_tick4", 32'(frameTick), 0);
    chk("lat_bounce", 32'(bounceCount), 0);

    // exact-fit landing then corner reflection
    doReset();
    stepSize = 4'd8;
    repeat (20) frame(ticks);
    chkPos("fit20", 400, 320, 1, 1, 0);
    frame(ticks);
    chkPos("corner21", 400, 320, 0, 0, 2);
    frame(ticks);
    chkPos("after22", 392, 312, 0, 0, 2);

    // walk left to 4 (top edge reflects on the way), then left-edge bounce
    stepSize = 4'd4;
    repeat (97) frame(ticks);
    chkPos("walk97", 4, 72, 0, 1, 3);
    stepSize = 4'd8;
    frame(ticks);
    chkPos("leftBounce", 0, 80, 1, 1, 4);

    // enable gating and zero step
    enable = 1'b0;
    begin
      int sum = 0;
      repeat (5) begin
        frame(ticks);
        sum += ticks;
      end
      chk("gate_ticks", 32'(sum), 0);
    end
    chkPos("gate_pos", 0, 80, 1, 1, 4);
    enable   = 1'b1;
    stepSize = 4'd0;
    frame(ticks);
    chk("zero_ticks", 32'(ticks), 1);
    chkPos("zero_pos", 0, 80, 1, 1, 4);

    // step latched at trigger; enable drop mid-sequence does not abort
    stepSize = 4'd8;
    trig();
    stepSize = 4'd15;
    enable   = 1'b0;
    ticks = 0;
    repeat (4) begin
      @(negedge pixelClock);
      if (frameTick === 1'b1) ticks++;
    end
    chk("latch_ticks", 32'(ticks), 1);
    chkPos("latch_pos", 8, 88, 1, 1, 4);
    enable = 1'b1;

    // insideBox coverage at (240,160)
    doReset();
    pix("in_tl", 240, 160, 1'b1, 1);
    pix("in_right", 479, 160, 1'b1, 1);
    pix("out_right", 480, 160, 1'b1, 0);
    pix("out_left", 239, 200, 1'b1, 0);
    pix("in_bottom", 240, 319, 1'b1, 1);
    pix("out_bottom", 240, 320, 1'b1, 0);
    pix("in_mid", 300, 200, 1'b1, 1);
    pix("blank", 300, 200, 1'b0, 0);
    hPosCounter = 10'd1;
    vPosCounter = 10'd0;

    // bounce counter saturation
    stepSize = 4'd15;
    repeat (5000) frame(ticks);
    chk("saturate", 32'(bounceCount), 255);

    // reset asserted while in STEP_V
    trig();
    @(negedge pixelClock);
    #2 resetN = 1'b0;
    #1;
    chkPos("midReset", 240, 160, 1, 1, 0);
    chk("midReset_tick", 32'(frameTick), 0);
    chk("midReset_inside", 32'(insideBox), 0);
    @(negedge pixelClock);
    resetN = 1'b1;
    ticks = 0;
    repeat (4) begin
      @(negedge pixelClock);
      if (frameTick === 1'b1) ticks++;
    end
    chk("midReset_noTick", 32'(ticks), 0);
    stepSize = 4'd2;
    frame(ticks);
    chk("postReset_ticks", 32'(ticks), 1);
    chkPos("postReset_pos", 242, 162, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/box_motion_scheduler.md
Name: box_motion_scheduler

Overview:
- Per-frame motion controller for the bouncing-box pattern generator.
- Watches the video timing counters from hdmi_tx and, once per frame during vertical blanking, advances the box top-left position by a programmable step.
- Reverses direction at the active-area edges and produces a registered in-box flag that the pixel mux uses to choose between box colour and background colour.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- BOX_W, 240, box width in pixels.
- BOX_H, 160, box height in lines.
- INIT_H, 240, reset horizontal position.
- INIT_V, 160, reset vertical position.
- TRIG_H, 0, hPosCounter value of the update trigger.
- TRIG_V, 480, vPosCounter value of the update trigger (must lie in blanking).

Ports:
- pixelClock  in  1  pixel clock; all logic on its rising edge.
- resetN  in  1  asynchronous active-low reset.
- enable  in  1  motion enable; when low, triggers are ignored.
- hPosCounter  in  10  horizontal timing counter from hdmi_tx.
- vPosCounter  in  10  vertical timing counter from hdmi_tx.
- inActiveDisplay  in  1  active-video flag from hdmi_tx.
- stepSize  in  4  pixels moved per frame on each axis.
- boxHpos  out  10  box left edge.
- boxVpos  out  10  box top edge.
- dirRight  out  1  1 = moving right.
- dirDown  out  1  1 = moving down.
- insideBox  out  1  registered box-coverage flag for the current pixel.
- frameTick  out  1  one-cycle pulse when an update completes.
- bounceCount  out  8  saturating count of edge reflections.

Behaviour:
- Reset (async assert, sync release):
  - boxHpos=INIT_H, boxVpos=INIT_V.
  - dirRight=1, dirDown=1.
  - insideBox=0, frameTick=0, bounceCount=0.
  - FSM enters WAIT.
- FSM states: WAIT, STEP_H, STEP_V, DONE.
- WAIT:
  - Trigger = hPosCounter==TRIG_H && vPosCounter==TRIG_V && enable.
  - On trigger: latch stepSize into stepReg, go to STEP_H.
  - Triggers arriving in any other state are ignored.
- STEP_H (one cycle), arithmetic in 11 bits:
  - Right-moving: if boxHpos+stepReg+BOX_W > H_ACTIVE, set boxHpos=H_ACTIVE-BOX_W and dirRight=0 (bounce); otherwise boxHpos+=stepReg.
  - Left-moving: if boxHpos < stepReg, set boxHpos=0 and dirRight=1 (bounce); otherwise boxHpos-=stepReg.
  - Next state: STEP_V.
- STEP_V: same rules on the vertical axis using V_ACTIVE, BOX_H, boxVpos and dirDown. Next state: DONE.
- DONE: frameTick=1 for exactly this cycle, then return to WAIT.
  - Trigger-to-frameTick latency: 3 cycles (trigger seen at edge N; H updated at N+1, V at N+2, frameTick high during N+3).
- bounceCount:
  - +1 per axis reflection, so a corner hit in one frame adds 2 (H in STEP_H, V in STEP_V).
  - Saturates at 255; never wraps.
- Exact-fit edge: landing exactly on the limit (e.g. boxHpos becomes H_ACTIVE-BOX_W) is not a bounce. Reflection happens on the next frame.
- stepSize=0: no position change, no bounce, frameTick still pulses.
- stepSize changes mid-update have no effect; only the value latched at the trigger is used.
- enable dropping after the trigger: the update sequence completes.
- insideBox, registered, 1-cycle latency:
  - Next value = inActiveDisplay && hPosCounter>=boxHpos && hPosCounter<boxHpos+BOX_W && vPosCounter>=boxVpos && vPosCounter<boxVpos+BOX_H.
  - Compare sums are computed in 11 bits.
- Position registers change only between the trigger and DONE. With TRIG_V in blanking, insideBox never changes shape within a visible frame.
- Reset asserted mid-sequence: immediate return to reset values; no frameTick.

Test Plan:
- Reset and first step: release reset, stepSize=1, enable=1, drive the counters to (0,480) -> boxHpos=241 and boxVpos=161 two cycles after the trigger edge; frameTick high 3 cycles after the trigger for 1 cycle; bounceCount=0.
- Corner bounce: stepSize=8, 20 triggers -> boxHpos=400, boxVpos=320, no bounce. Trigger 21 -> both positions hold at the limit, dirRight=0, dirDown=0, bounceCount=2. Trigger 22 -> boxHpos=392, boxVpos=312.
- Left/top bounce: from boxHpos=4 moving left with stepSize=8 -> boxHpos=0, dirRight=1, bounceCount increments by 1.
- Gating: enable=0 over 5 triggers -> position unchanged, no frameTick. stepSize=0 with enable=1 -> frameTick pulses, position unchanged.
- insideBox at box (240,160): pixel (240,160) active -> 1 one cycle later. (479,160) -> 1. (480,160) -> 0. (239,200) -> 0. Any pixel with inActiveDisplay=0 -> 0.
- Saturation and reset: force 300 bounces -> bounceCount=255. Assert resetN low while in STEP_V -> all outputs return to reset values asynchronously, no frameTick.
